// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - four-digit code entry game controller with timed target hint
module game_ctrl #(
   parameter int HINT_CYCLES = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_pulse,
   input  logic        hint_pulse,
   input  logic        key_valid,
   input  logic [3:0]  key_val,
   input  logic [15:0] target,
   output logic [1:0]  state,
   output logic        show_target,
   output logic        hint_active,
   output logic [15:0] entry,
   output logic [2:0]  entry_cnt,
   output logic [3:0]  err_cnt,
   output logic        pass
);

   localparam int TW = $clog2(HINT_CYCLES + 1);
   localparam logic [TW-1:0] HINT_LOAD = TW'(HINT_CYCLES);

   typedef enum logic [1:0] {S_INIT, S_SHOW, S_GAME, S_FINISH} state_t;

   state_t        st_q, st_n;
   logic [TW-1:0] timer_q, timer_n;
   logic [15:0]   entry_n;
   logic [2:0]    cnt_n;
   logic [3:0]    err_n;
   logic          key_ok;
   logic [15:0]   shifted;

   assign state   = st_q;
   assign key_ok  = key_valid && (key_val <= 4'd9);
   assign shifted = {entry[11:0], key_val};

   always_comb begin
      st_n    = st_q;
      timer_n = '0;
      entry_n = entry;
      cnt_n   = entry_cnt;
      err_n   = err_cnt;
      case (st_q)
         S_INIT: begin
            if (start_pulse) begin
               st_n    = S_SHOW;
               entry_n = '0;
               cnt_n   = '0;
               err_n   = '0;
            end
         end
         S_SHOW: begin
            if (start_pulse) st_n = S_GAME;
         end
         S_GAME: begin
            // A hint request reloads rather than extends a running hint
            if (hint_pulse)
               timer_n = HINT_LOAD;
            else if (timer_q != '0)
               timer_n = timer_q - TW'(1);
            if (key_ok) begin
               if (entry_cnt != 3'd3) begin
                  entry_n = shifted;
                  cnt_n   = entry_cnt + 3'd1;
               end else if (shifted == target) begin
                  st_n    = S_FINISH;
                  entry_n = shifted;
               end else begin
                  entry_n = '0;
                  cnt_n   = '0;
                  err_n   = (err_cnt == 4'd15) ? err_cnt : err_cnt + 4'd1;
               end
            end
            if (st_n != S_GAME) timer_n = '0;
         end
         S_FINISH: begin
            if (start_pulse) begin
               st_n    = S_INIT;
               entry_n = '0;
               cnt_n   = '0;
               err_n   = '0;
            end
         end
         default: st_n = S_INIT;
      endcase
   end

   // Display flags are registered from next-state values so they never glitch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q        <= S_INIT;
         timer_q     <= '0;
         entry       <= '0;
         entry_cnt   <= '0;
         err_cnt     <= '0;
         pass        <= 1'b0;
         hint_active <= 1'b0;
         show_target <= 1'b0;
      end else begin
         st_q        <= st_n;
         timer_q     <= timer_n;
         entry       <= entry_n;
         entry_cnt   <= cnt_n;
         err_cnt     <= err_n;
         pass        <= (st_n == S_FINISH);
         hint_active <= (timer_n != '0);
         show_target <= (st_n == S_SHOW) || (timer_n != '0);
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - randomized bench for game_ctrl against a queue-based game model
module tb_game_ctrl;

   localparam int HC = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_pulse = 1'b0;
   logic        hint_pulse = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_val = 4'd0;
   logic [15:0] target = 16'h1234;
   logic [1:0]  state;
   logic        show_target;
   logic        hint_active;
   logic [15:0] entry;
   logic [2:0]  entry_cnt;
   logic [3:0]  err_cnt;
   logic        pass;

   game_ctrl #(.HINT_CYCLES(HC)) dut (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .hint_pulse(hint_pulse),
      .key_valid(key_valid), .key_val(key_val), .target(target), .state(state),
      .show_target(show_target), .hint_active(hint_active), .entry(entry),
      .entry_cnt(entry_cnt), .err_cnt(err_cnt), .pass(pass)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: phase number, queue of entered digits, error count, hint cycles left
   int m_phase = 0;
   int m_digits[$];
   int m_errs = 0;
   int m_hint = 0;

   function automatic int m_entry();
      int v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      return v;
   endfunction

   always @(posedge clk or negedge rst) begin
      int nh;
      int code;
      if (!rst) begin
         m_phase = 0;
         m_digits.delete();
         m_errs = 0;
         m_hint = 0;
      end else begin
         case (m_phase)
            0: if (start_pulse) begin m_phase = 1; m_digits.delete(); m_errs = 0; end
            1: if (start_pulse) m_phase = 2;
            3: if (start_pulse) begin m_phase = 0; m_digits.delete(); m_errs = 0; end
            default: begin
               nh = (m_hint > 0) ? m_hint - 1 : 0;
               if (hint_pulse) nh = HC;
               if (key_valid && key_val < 10) begin
                  if (m_digits.size() < 3) begin
                     m_digits.push_back(int'(key_val));
                  end else begin
                     code = m_entry() * 16 + int'(key_val);
                     if (code == int'(target)) begin
                        m_digits.push_back(int'(key_val));
                        m_phase = 3;
                     end else begin
                        m_digits.delete();
                        if (m_errs < 15) m_errs++;
                     end
                  end
               end
               m_hint = (m_phase == 2) ? nh : 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("state", int'(state), m_phase);
         check("entry", int'(entry), m_entry());
         check("entry_cnt", int'(entry_cnt), (m_digits.size() > 3) ? 3 : m_digits.size());
         check("err_cnt", int'(err_cnt), m_errs);
         check("pass", int'(pass), int'(m_phase == 3));
         check("hint_active", int'(hint_active), int'(m_hint > 0));
         check("show_target", int'(show_target), int'(m_phase == 1 || m_hint > 0));
      end
   end

   task automatic drive(input logic sp, input logic hp, input logic kv, input logic [3:0] kd);
      start_pulse = sp;
      hint_pulse  = hp;
      key_valid   = kv;
      key_val     = kd;
      @(negedge clk);
      start_pulse = 1'b0;
      hint_pulse  = 1'b0;
      key_valid   = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic key(input int d);
      drive(1'b0, 1'b0, 1'b1, 4'(d));
   endtask

   task automatic code4(input int a, input int b, input int c, input int d);
      key(a); key(b); key(c); key(d);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_entry"}, int'(entry), 0);
      check({tag, "_cnt"}, int'(entry_cnt), 0);
      check({tag, "_err"}, int'(err_cnt), 0);
      check({tag, "_pass"}, int'(pass), 0);
      check({tag, "_hint"}, int'(hint_active), 0);
      check({tag, "_show"}, int'(show_target), 0);
   endtask

   initial begin
      int n_act;
      int n_show;
      int idx;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      cmp_en = 1'b1;

      // Correct code first time
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      check("show_state", int'(state), 1);
      check("show_flag", int'(show_target), 1);
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      check("game_state", int'(state), 2);
      code4(1, 2, 3, 4);
      check("win_state", int'(state), 3);
      check("win_pass", int'(pass), 1);
      check("win_err", int'(err_cnt), 0);
      check("win_entry", int'(entry), 16'h1234);
      key(7);
      check("finish_key_entry", int'(entry), 16'h1234);
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      check("restart_state", int'(state), 0);
      check("restart_pass", int'(pass), 0);
      key(5);
      check("init_key_cnt", int'(entry_cnt), 0);
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      key(5);
      check("show_key_cnt", int'(entry_cnt), 0);
      drive(1'b1, 1'b0, 1'b0, 4'd0);

      // Wrong codes, saturation, illegal keys, start ignored in GAME
      code4(1, 2, 3, 5);
      check("miss_entry", int'(entry), 0);
      check("miss_cnt", int'(entry_cnt), 0);
      check("miss_err", int'(err_cnt), 1);
      check("miss_state", int'(state), 2);
      repeat (17) code4(1, 2, 3, 5);
      check("err_sat", int'(err_cnt), 15);
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      check("game_start_ignored", int'(state), 2);
      key(1); key(2);
      key(11);
      check("illegal_entry", int'(entry), 16'h0012);
      check("illegal_cnt", int'(entry_cnt), 2);

      // Hint duration and reload
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      n_act = 0; n_show = 0;
      repeat (8) begin
         if (hint_active) n_act++;
         if (show_target) n_show++;
         idle();
      end
      check("hint_len", n_act, 5);
      check("hint_show_len", n_show, 5);
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      n_act = 0;
      for (int i = 0; i < 12; i++) begin
         if (hint_active) n_act++;
         drive(1'b0, (i == 2), 1'b0, 4'd0);
      end
      check("hint_reload_len", n_act, 8);

      // Asynchronous reset during hint with two digits entered
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      check("pre_rst_cnt", int'(entry_cnt), 2);
      check("pre_rst_hint", int'(hint_active), 1);
      #2 rst = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      key(3); idle();
      check("post_rst_state", int'(state), 0);
      check("post_rst_cnt", int'(entry_cnt), 0);

      // Randomized play
      for (int it = 0; it < 4000; it++) begin
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b0;
            #1 check("rnd_rst_state", int'(state), 0);
            @(negedge clk);
            rst = 1'b1;
         end else begin
            if ($urandom_range(0, 299) == 0)
               target = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            idx = (m_digits.size() < 4) ? m_digits.size() : 0;
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7) ? 4'((target >> (12 - 4 * idx)) & 16'hf)
                                              : 4'($urandom_range(0, 15)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
